// File: rtl/conv_pkg.sv
// Shared sizing defaults, saturation limits and FSM state encoding for the
// convolution accumulator.
package conv_pkg;

  localparam int LANES_DEF  = 64;
  localparam int PROD_W_DEF = 32;
  localparam int ACC_W_DEF  = 48;

  localparam logic signed [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic signed [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/conv_adder_tree.sv
// Masked, sign-extending LANES-input reduction tree: six adder levels with a
// register after every two, carrying a valid bit and a first-beat tag.
module conv_adder_tree #(
  parameter int LANES  = 64,
  parameter int PROD_W = 32,
  parameter int SUM_W  = 48
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_first,
  input  logic [LANES*PROD_W-1:0] prod,
  input  logic [LANES-1:0]        en,
  output logic signed [SUM_W-1:0] sum,
  output logic                    sum_valid,
  output logic                    sum_first,
  output logic                    pending
);

  logic signed [SUM_W-1:0] lane [LANES];
  logic signed [SUM_W-1:0] lvl1 [LANES/2];
  logic signed [SUM_W-1:0] lvl2 [LANES/4];
  logic signed [SUM_W-1:0] p0   [LANES/4];
  logic signed [SUM_W-1:0] lvl3 [LANES/8];
  logic signed [SUM_W-1:0] lvl4 [LANES/16];
  logic signed [SUM_W-1:0] p1   [LANES/16];
  logic signed [SUM_W-1:0] lvl5 [LANES/32];
  logic signed [SUM_W-1:0] total;
  logic signed [PROD_W-1:0] raw;
  logic vld_p0, vld_p1, vld_p2;
  logic first_p0, first_p1, first_p2;

  // Stage 0: mask, sign-extend, levels 1-2
  always_comb begin
    raw = '0;
    for (int i = 0; i < LANES; i++) begin
      raw     = prod[i*PROD_W +: PROD_W];
      lane[i] = en[i] ? {{(SUM_W-PROD_W){raw[PROD_W-1]}}, raw} : '0;
    end
    for (int i = 0; i < LANES/2; i++) lvl1[i] = lane[2*i] + lane[2*i+1];
    for (int i = 0; i < LANES/4; i++) lvl2[i] = lvl1[2*i] + lvl1[2*i+1];
  end

  // Stage 1: levels 3-4
  always_comb begin
    for (int i = 0; i < LANES/8; i++)  lvl3[i] = p0[2*i] + p0[2*i+1];
    for (int i = 0; i < LANES/16; i++) lvl4[i] = lvl3[2*i] + lvl3[2*i+1];
  end

  // Stage 2: levels 5-6
  always_comb begin
    total = '0;
    for (int i = 0; i < LANES/32; i++) lvl5[i] = p1[2*i] + p1[2*i+1];
    for (int i = 0; i < LANES/32; i++) total = total + lvl5[i];
  end

  always_ff @(posedge clk) begin
    if (in_valid) p0  <= lvl2;
    if (vld_p0)   p1  <= lvl4;
    if (vld_p1)   sum <= total;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      first_p0 <= 1'b0;
      first_p1 <= 1'b0;
      first_p2 <= 1'b0;
    end else begin
      vld_p0   <= in_valid;
      vld_p1   <= vld_p0;
      vld_p2   <= vld_p1;
      first_p0 <= in_valid & in_first;
      first_p1 <= first_p0;
      first_p2 <= first_p1;
    end
  end

  assign sum_valid = vld_p2;
  assign sum_first = first_p2;
  assign pending   = vld_p0 | vld_p1;

endmodule

// File: rtl/conv_accumulator.sv
// Window accumulator behind the 64-lane multiplier: tree-reduces each beat,
// accumulates a kernel window and hands one result downstream.
// Define CONV_ACC_SAT_EN to saturate the accumulator instead of wrapping.
module conv_accumulator
  import conv_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*PROD_W-1:0] Mult_out,
  input  logic [LANES-1:0]        MUL_EN,
  input  logic                    Overflow_Mul,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    acc_ovf,
  output logic                    busy
);

`ifdef CONV_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  // Returns {overflow, result}; the result clamps when saturation is built in.
  function automatic logic [ACC_W:0] acc_add(input logic signed [ACC_W-1:0] a,
                                             input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W-1:0] s;
    logic ovf;
    s   = a + b;
    ovf = (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
`ifdef CONV_ACC_SAT_EN
    if (ovf) s = a[ACC_W-1] ? SAT_MIN : SAT_MAX;
`endif
    return {ovf, s};
  endfunction

  state_t state_q, state_d;
  logic run_q;
  logic accept, finalize, release_out;
  logic signed [ACC_W-1:0] sum_p2, acc_q, acc_nxt;
  logic vld_p2, first_p2, pending;
  logic [ACC_W:0] add_res;
  logic ovf_now, sticky_q;

  assign in_ready    = run_q && (state_q == IDLE || state_q == ACCUM);
  assign accept      = in_valid && in_ready;
  assign out_valid   = (state_q == HOLD);
  assign busy        = (state_q != IDLE);
  assign release_out = out_valid && out_ready;
  assign finalize    = (state_q == DRAIN) && vld_p2 && !pending;

  conv_adder_tree #(
    .LANES (LANES),
    .PROD_W(PROD_W),
    .SUM_W (ACC_W)
  ) u_tree (
    .clk      (clk),
    .rst      (rst),
    .in_valid (accept),
    .in_first (state_q == IDLE),
    .prod     (Mult_out),
    .en       (MUL_EN),
    .sum      (sum_p2),
    .sum_valid(vld_p2),
    .sum_first(first_p2),
    .pending  (pending)
  );

  // Accumulate stage: first result of a window overwrites instead of adding
  always_comb begin
    add_res = acc_add(acc_q, sum_p2);
    acc_nxt = acc_q;
    ovf_now = 1'b0;
    if (vld_p2) begin
      if (first_p2) begin
        acc_nxt = sum_p2;
      end else begin
        acc_nxt = add_res[ACC_W-1:0];
        ovf_now = add_res[ACC_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = in_last ? DRAIN : ACCUM;
      ACCUM:   if (accept && in_last) state_d = DRAIN;
      DRAIN:   if (finalize) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      run_q    <= 1'b0;
      acc_q    <= '0;
      sticky_q <= 1'b0;
      acc_out  <= '0;
      acc_ovf  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (release_out) begin
        acc_q    <= '0;
        sticky_q <= 1'b0;
      end else begin
        acc_q    <= acc_nxt;
        sticky_q <= sticky_q | ovf_now | (accept & Overflow_Mul);
      end
      // Result is loaded from the same-cycle accumulate to save a cycle
      if (finalize) begin
        acc_out <= acc_nxt;
        acc_ovf <= sticky_q | ovf_now;
      end
    end
  end

endmodule

// File: tb/tb_conv_accumulator.sv
// Directed bench for conv_accumulator (ACC_W = 38 so two full-scale beats overflow).
module tb_conv_accumulator;

  localparam int LANES  = 64;
  localparam int PROD_W = 32;
  localparam int ACC_W  = 38;
  localparam int DW     = LANES * PROD_W;

  logic             clk;
  logic             rst;
  logic [DW-1:0]    Mult_out;
  logic [LANES-1:0] MUL_EN;
  logic             Overflow_Mul;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [ACC_W-1:0] acc_out;
  logic             out_valid;
  logic             out_ready;
  logic             acc_ovf;
  logic             busy;

  int passed = 0;
  int total  = 0;

  conv_accumulator #(
    .LANES (LANES),
    .PROD_W(PROD_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Mult_out    (Mult_out),
    .MUL_EN      (MUL_EN),
    .Overflow_Mul(Overflow_Mul),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .acc_out     (acc_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .acc_ovf     (acc_ovf),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] pack_alt(input logic [31:0] a, input logic [31:0] b);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r[i*PROD_W +: PROD_W] = (i % 2 == 0) ? a : b;
    return r;
  endfunction

  function automatic logic [DW-1:0] pack_first_n(input int n, input logic [31:0] v);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i*PROD_W +: PROD_W] = v;
    return r;
  endfunction

  task automatic beat(input logic [DW-1:0] d, input logic [LANES-1:0] en,
                      input logic last, input logic movf);
    Mult_out     = d;
    MUL_EN       = en;
    in_last      = last;
    Overflow_Mul = movf;
    in_valid     = 1'b1;
    @(posedge clk); #1;
    in_valid     = 1'b0;
    in_last      = 1'b0;
    Overflow_Mul = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 64'(out_valid), 64'd1);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ovalid"}, 64'(out_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
  endtask

  localparam logic [LANES-1:0] ALL = {LANES{1'b1}};

  initial begin
    logic [ACC_W-1:0] exp_ovf_val;
    rst = 1'b1; Mult_out = '0; MUL_EN = '0; Overflow_Mul = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_acc_out", 64'(acc_out), 64'd0);
    check("rst_acc_ovf", 64'(acc_ovf), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // single-beat window, latency = 4 cycles from accept
    beat(pack_alt(32'd1, 32'd1), ALL, 1'b1, 1'b0);
    repeat (2) @(posedge clk); #1;
    check("lat_early", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_t4", 64'(out_valid), 64'd1);
    check("ones_sum", 64'(acc_out), 64'd64);
    check("ones_ovf", 64'(acc_ovf), 64'd0);
    check("hold_in_ready", 64'(in_ready), 64'd0);
    release_out("ones_rel");

    // masking and sign: even lanes +5, odd lanes -3, upper half disabled
    beat(pack_alt(32'd5, -32'sd3), {32'h0, 32'hFFFF_FFFF}, 1'b1, 1'b0);
    wait_out("mask_valid");
    check("mask_sum", 64'(acc_out), 64'd32);
    release_out("mask_rel");

    // out_ready without out_valid in IDLE
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stray_ready_busy", 64'(busy), 64'd0);

    // three back-to-back beats: 100, -40, 7
    beat(pack_first_n(1, 32'd100), ALL, 1'b0, 1'b0);
    check("accum_ready1", 64'(in_ready), 64'd1);
    beat(pack_first_n(1, -32'sd40), ALL, 1'b0, 1'b0);
    check("accum_ready2", 64'(in_ready), 64'd1);
    beat(pack_first_n(1, 32'd7), ALL, 1'b1, 1'b0);
    check("drain_ready", 64'(in_ready), 64'd0);
    wait_out("three_valid");
    check("three_sum", 64'(acc_out), 64'd67);

    // backpressure for 10 cycles
    repeat (10) @(posedge clk); #1;
    check("bp_acc_out", 64'(acc_out), 64'd67);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    release_out("bp_rel");

    // following window starts from zero
    beat(pack_first_n(9, 32'd1), ALL, 1'b1, 1'b0);
    wait_out("fresh_valid");
    check("fresh_sum", 64'(acc_out), 64'd9);
    release_out("fresh_rel");

    // window with an input bubble: 3, gap, 4
    beat(pack_first_n(1, 32'd3), ALL, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("bubble_busy", 64'(busy), 64'd1);
    beat(pack_first_n(1, 32'd4), ALL, 1'b1, 1'b0);
    wait_out("bubble_valid");
    check("bubble_sum", 64'(acc_out), 64'd7);
    release_out("bubble_rel");

    // accumulator overflow: two full-scale beats
`ifdef CONV_ACC_SAT_EN
    exp_ovf_val = 38'h1F_FFFF_FFFF;
`else
    exp_ovf_val = 38'h3F_FFFF_FF80;
`endif
    beat(pack_alt(32'h7FFF_FFFF, 32'h7FFF_FFFF), ALL, 1'b0, 1'b0);
    beat(pack_alt(32'h7FFF_FFFF, 32'h7FFF_FFFF), ALL, 1'b1, 1'b0);
    wait_out("ovf_valid");
    check("ovf_flag", 64'(acc_ovf), 64'd1);
    check("ovf_value", 64'(acc_out), 64'(exp_ovf_val));
    release_out("ovf_rel");

    // multiplier overflow flag with zero data
    beat('0, ALL, 1'b1, 1'b1);
    wait_out("mulovf_valid");
    check("mulovf_flag", 64'(acc_ovf), 64'd1);
    check("mulovf_value", 64'(acc_out), 64'd0);
    release_out("mulovf_rel");

    // sticky flag cleared for the next clean window
    beat(pack_alt(32'd1, 32'd1), ALL, 1'b1, 1'b0);
    wait_out("clean_valid");
    check("clean_flag", 64'(acc_ovf), 64'd0);
    check("clean_sum", 64'(acc_out), 64'd64);
    release_out("clean_rel");

    // reset in the middle of a window
    beat(pack_first_n(1, 32'd50), ALL, 1'b0, 1'b0);
    beat(pack_first_n(1, 32'd60), ALL, 1'b0, 1'b0);
    check("mid_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_acc_out", 64'(acc_out), 64'd0);
    check("mid_rst_acc_ovf", 64'(acc_ovf), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    beat(pack_first_n(9, 32'd1), ALL, 1'b1, 1'b0);
    wait_out("after_rst_valid");
    check("after_rst_sum", 64'(acc_out), 64'd9);
    release_out("after_rst_rel");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/conv_accumulator.md
Name: conv_accumulator

Overview:
- Downstream neighbour of the 64-lane multiplication stage.
- Consumes one 64-lane beat of signed 32-bit products per cycle and masks off disabled lanes.
- Reduces each beat through a pipelined adder tree and accumulates beats over one kernel window; the window may span several beats.
- Presents one signed result per window with a valid/ready handshake toward the activation/output stage.

Parameters:
- LANES, 64, number of product lanes; must be a power of 2
- PROD_W, 32, width of each signed product
- ACC_W, 48, accumulator and result width, signed two's complement

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- Mult_out  in  LANES*PROD_W  packed products; lane i occupies bits [i*PROD_W +: PROD_W]
- MUL_EN  in  LANES  lane enable mask; disabled lanes contribute 0
- Overflow_Mul  in  1  multiplier overflow flag for the current beat
- in_valid  in  1  beat present on Mult_out/MUL_EN
- in_last  in  1  beat is the final one of the window; qualified by in_valid
- in_ready  out  1  block accepts a beat this cycle
- acc_out  out  ACC_W  window result
- out_valid  out  1  acc_out is valid
- out_ready  in  1  downstream accepts the result
- acc_ovf  out  1  window overflowed (accumulator or multiplier); valid with out_valid
- busy  out  1  state is not IDLE

Behaviour:
- Reset: all of the following are 0 and state = IDLE: in_ready, acc_out, out_valid, acc_ovf, busy, pipeline valids, accumulator, sticky flags. in_ready rises in the first cycle after rst deasserts.
- Beat accept: in_valid && in_ready.
- in_ready = 1 in IDLE and ACCUM; 0 in DRAIN and HOLD.
- Lane masking: a lane whose MUL_EN bit is 0 is forced to 0 before the adder tree.
- Products are sign-extended to ACC_W.
- Adder tree: log2(LANES) = 6 levels, with a register after every 2 levels, giving 3 stages.
- Accumulator: updates in the cycle after the tree output is valid.
- Latency: accept of the last beat at cycle T gives out_valid = 1 at T+4.
- Throughput: 1 beat per cycle inside a window.
- States:
  - IDLE: on accept, go to ACCUM. If in_last is also 1, go directly to DRAIN (single-beat window).
  - ACCUM: accept beats; on accept with in_last = 1, go to DRAIN.
  - DRAIN: wait until the tree pipeline is empty and the final accumulate is done, then load acc_out, assert out_valid, and go to HOLD.
  - HOLD: out_valid = 1 and acc_out/acc_ovf hold stable until out_ready. On out_valid && out_ready: clear accumulator and sticky flags, out_valid = 0, go to IDLE.
- Accumulator clearing: the first tree result of a window overwrites the accumulator rather than adding to it; a first-beat tag travels with the pipeline valid bit.
- Overflow:
  - Tree nodes are sized so they never overflow: PROD_W + 6 bits ≤ ACC_W.
  - Accumulator overflow is signed overflow of the ACC_W add (operand signs equal, result sign differs).
  - acc_ovf = sticky OR over the window of accumulator overflow and every accepted beat's Overflow_Mul.
- in_valid with MUL_EN = 0: the beat is accepted and contributes 0.
- in_valid = 0 inside ACCUM: the state holds; pipeline bubbles are ignored.
- out_ready asserted without out_valid: ignored.
- rst mid-window: everything is discarded and the block returns to reset values.

Optional Feature:
- Macro: CONV_ACC_SAT_EN.
- Defined: on accumulator overflow, the value clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1) according to the operand sign. Later beats continue from the clamped value. acc_ovf still sets.
- Undefined: the accumulator wraps modulo 2^ACC_W and acc_ovf sets.

Decomposition:
- Package conv_pkg:
  - LANES, PROD_W, ACC_W defaults
  - state enum (IDLE, ACCUM, DRAIN, HOLD)
  - ACC_MAX and ACC_MIN constants
- Sub-module: conv_adder_tree.
  - Masked LANES-input signed reduction with its 3 register stages and a valid/first-tag sideband.
  - Instantiated once.

Test Plan:
- Single-beat window: all lanes = 1, MUL_EN all 1s, in_last = 1 → acc_out = 64, out_valid at accept+4, acc_ovf = 0.
- Masking and sign: lanes alternate +5/-3, MUL_EN = 0x00000000FFFFFFFF → acc_out = 16*5 - 16*3 = 32.
- Three-beat window back-to-back: beat sums 100, -40, 7 → acc_out = 67; in_ready stays 1 through ACCUM and drops in DRAIN.
- Backpressure: hold out_ready = 0 for 10 cycles → acc_out stable, in_ready = 0. Release → IDLE next cycle; the following window starts from 0, not 67.
- Overflow: 2 beats, every lane = 0x7FFFFFFF, ACC_W = 38 → acc_ovf = 1. With CONV_ACC_SAT_EN, acc_out = 2^37-1. Separately, a beat with Overflow_Mul = 1 and zero data → acc_ovf = 1.
- Reset mid-window: assert rst during ACCUM after 2 beats → all outputs 0. The next 1-beat window of sum 9 → acc_out = 9.
